clk_div_multi: RTL

//   Multi-channel programmable tick/clock-enable generator. Successor to the fixed single-output divider.

---
 rtl/clk_div_multi.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi
//   Multi-channel programmable tick / clock-enable generator. Each channel
//   has its own counter, divisor D and mode. Pulse mode produces a
//   one-cycle-high output with period D. Square mode produces an output that
//   is high for floor(D/2) cycles and low for ceil(D/2) cycles. Divisor and
//   mode updates are taken over a valid/ready port into a per-channel shadow
//   register. They are applied only at that channel's wrap, or on the next
//   edge while the channel is disabled, so an output period is never cut short.
//
// Parameters
//   CHANNELS     number of independent channels (>=1)
//   WIDTH        counter/divisor width
//   DEFAULT_DIV  divisor loaded into every channel at reset (>=2)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   en         per-channel run enable
//   cfg_valid  config request valid
//   cfg_ready  config request accepted when cfg_valid && cfg_ready
//   cfg_ch     target channel; out-of-range index is always ready and ignored
//   cfg_div    requested divisor (values below 2 are treated as 2)
//   cfg_mode   requested mode: 0 = pulse, 1 = square
//   out        per-channel registered output
//   sync       global restart of all enabled channels (only with CLK_DIV_SYNC_EN)
//
// Build option
//   CLK_DIV_SYNC_EN  adds the sync port. On an edge where sync=1, every enabled
//                    channel restarts: the counter clears, any pending update is
//                    applied, and the output takes the mode's restart level.
//                    No tick is emitted on that edge.

module clk_div_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 50_000_000,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic [CHANNELS-1:0] out
`ifdef CLK_DIV_SYNC_EN
  ,
  input  logic                sync
`endif
);

  localparam logic [WIDTH-1:0] DIV_MIN  = WIDTH'(2);
  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0]    cnt_q     [CHANNELS];
  logic [WIDTH-1:0]    cnt_d     [CHANNELS];
  logic [WIDTH-1:0]    div_q     [CHANNELS];
  logic [WIDTH-1:0]    div_d     [CHANNELS];
  logic [WIDTH-1:0]    shd_div_q [CHANNELS];
  logic [WIDTH-1:0]    shd_div_d [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] shd_mode_q, shd_mode_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] out_q, out_d;

  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] half;
  logic [CHANNELS-1:0] restart;
  logic [CHANNELS-1:0] apply;
  logic [WIDTH-1:0]    cfg_div_clamped;

  // Clamping is done once at acceptance, so stored divisors are always >=2.
  // That keeps D-1 and (D>>1)-1 from underflowing.
  assign cfg_div_clamped = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

  // Ready depends only on the addressed channel's pending flag. Any index that
  // matches no channel leaves ready at 1 and the request is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend_q[i];
    end
  end

  always_comb begin
    accept  = '0;
    wrap    = '0;
    half    = '0;
    restart = '0;
    apply   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]      = cnt_q[i];
      div_d[i]      = div_q[i];
      shd_div_d[i]  = shd_div_q[i];
      mode_d[i]     = mode_q[i];
      shd_mode_d[i] = shd_mode_q[i];
      pend_d[i]     = pend_q[i];
      out_d[i]      = out_q[i];

      accept[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
      wrap[i]   = (cnt_q[i] == div_q[i] - ONE);
      half[i]   = (cnt_q[i] == (div_q[i] >> 1) - ONE);
`ifdef CLK_DIV_SYNC_EN
      restart[i] = sync && en[i];
`endif

      if (!en[i]) begin
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
        apply[i] = pend_q[i];
      end else if (restart[i]) begin
        // Restart takes priority over a natural wrap in the same cycle.
        // The restart level follows whichever mode will govern the new period.
        cnt_d[i] = '0;
        apply[i] = pend_q[i];
        out_d[i] = pend_q[i] ? shd_mode_q[i] : mode_q[i];
      end else if (wrap[i]) begin
        cnt_d[i] = '0;
        out_d[i] = 1'b1;
        apply[i] = pend_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
        if (!mode_q[i] || half[i]) out_d[i] = 1'b0;
      end

      // accept needs pend_q=0 and apply needs pend_q=1, so they never collide.
      // An update accepted on a wrap edge therefore waits for the following wrap.
      if (apply[i]) begin
        div_d[i]  = shd_div_q[i];
        mode_d[i] = shd_mode_q[i];
        pend_d[i] = 1'b0;
      end
      if (accept[i]) begin
        shd_div_d[i]  = cfg_div_clamped;
        shd_mode_d[i] = cfg_mode;
        pend_d[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]     <= '0;
        div_q[i]     <= DIV_RST;
        shd_div_q[i] <= DIV_RST;
      end
      mode_q     <= '0;
      shd_mode_q <= '0;
      pend_q     <= '0;
      out_q      <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]     <= cnt_d[i];
        div_q[i]     <= div_d[i];
        shd_div_q[i] <= shd_div_d[i];
      end
      mode_q     <= mode_d;
      shd_mode_q <= shd_mode_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
    end
  end

  assign out = out_q;

endmodule
